// File: rtl/imu_axis_filter_if.sv
// IMU filter bus: raw frame input from the SPI reader and the filtered
// three-axis result toward the consumer.
interface imu_axis_filter_if;
  logic [47:0]        raw_data;
  logic               raw_valid;
  logic               recal;
  logic signed [15:0] x_out;
  logic signed [15:0] y_out;
  logic signed [15:0] z_out;
  logic               out_valid;
  logic               calibrated;

  modport master (
    output raw_data, raw_valid, recal,
    input  x_out, y_out, z_out, out_valid, calibrated
  );

  modport slave (
    input  raw_data, raw_valid, recal,
    output x_out, y_out, z_out, out_valid, calibrated
  );
endinterface

// File: rtl/imu_axis_filter.sv
// Per-sensor IMU axis conditioning: frame split, zero-bias calibration,
// saturating bias removal and power-of-two boxcar smoothing.
module imu_axis_filter #(
  parameter int CAL_SHIFT = 6,
  parameter int AVG_SHIFT = 2,
  parameter bit BYTE_SWAP = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  imu_axis_filter_if.slave bus
);
  localparam int DATA_W = 16;
  localparam int ACC_W  = DATA_W + CAL_SHIFT;
  localparam int SUM_W  = DATA_W + AVG_SHIFT;
  localparam int HIST_N = 1 << AVG_SHIFT;
  localparam int CNT_W  = CAL_SHIFT + 1;
  localparam logic [CNT_W-1:0]         CNT_LAST = CNT_W'((1 << CAL_SHIFT) - 1);
  localparam logic signed [DATA_W:0]   SAT_HI   = 17'sh07FFF;
  localparam logic signed [DATA_W:0]   SAT_LO   = 17'sh18000;

  typedef enum logic {ST_CAL, ST_RUN} state_t;

  state_t                   state_q, state_d;
  logic                     rv_q, rv_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic signed [ACC_W-1:0]  acc_q [3];
  logic signed [ACC_W-1:0]  acc_d [3];
  logic signed [DATA_W-1:0] bias_q [3];
  logic signed [DATA_W-1:0] bias_d [3];
  logic signed [DATA_W-1:0] corr_p1_q [3];
  logic signed [DATA_W-1:0] corr_p1_d [3];
  logic                     vld_p1_q, vld_p1_d;
  logic signed [SUM_W-1:0]  sum_p2_q [3];
  logic signed [SUM_W-1:0]  sum_p2_d [3];
  logic signed [DATA_W-1:0] hist_p2_q [3][HIST_N];
  logic signed [DATA_W-1:0] hist_p2_d [3][HIST_N];
  logic signed [DATA_W-1:0] out_p2_q [3];
  logic signed [DATA_W-1:0] out_p2_d [3];
  logic                     vld_p2_q, vld_p2_d;

  logic                     accept, take, cal_done, calibrated;
  logic signed [DATA_W-1:0] axis_p0 [3];
  logic signed [ACC_W-1:0]  acc_new [3];
  logic signed [SUM_W-1:0]  sum_new [3];

  function automatic logic signed [DATA_W-1:0] order_bytes(input logic [7:0] b0,
                                                          input logic [7:0] b1);
    return BYTE_SWAP ? {b1, b0} : {b0, b1};
  endfunction

  function automatic logic signed [DATA_W-1:0] sat_sub(input logic signed [DATA_W-1:0] a,
                                                      input logic signed [DATA_W-1:0] b);
    logic signed [DATA_W:0] diff;
    diff = $signed({a[DATA_W-1], a}) - $signed({b[DATA_W-1], b});
    if (diff > SAT_HI) return SAT_HI[DATA_W-1:0];
    if (diff < SAT_LO) return SAT_LO[DATA_W-1:0];
    return diff[DATA_W-1:0];
  endfunction

  // Stage 0: rising-edge frame acceptance and axis split
  always_comb begin
    rv_d       = bus.raw_valid;
    accept     = bus.raw_valid & ~rv_q;
    take       = accept & ~bus.recal;
    cal_done   = take && (state_q == ST_CAL) && (cnt_q == CNT_LAST);
    axis_p0[0] = order_bytes(bus.raw_data[47:40], bus.raw_data[39:32]);
    axis_p0[1] = order_bytes(bus.raw_data[31:24], bus.raw_data[23:16]);
    axis_p0[2] = order_bytes(bus.raw_data[15:8],  bus.raw_data[7:0]);
  end

  always_comb begin
    state_d = state_q;
    if (bus.recal)     state_d = ST_CAL;
    else if (cal_done) state_d = ST_RUN;
  end

  always_comb begin
    calibrated = (state_q == ST_RUN);
  end

  always_comb begin
    cnt_d    = cnt_q;
    vld_p1_d = 1'b0;
    vld_p2_d = 1'b0;
    for (int i = 0; i < 3; i++) begin
      acc_d[i]     = acc_q[i];
      bias_d[i]    = bias_q[i];
      corr_p1_d[i] = corr_p1_q[i];
      sum_p2_d[i]  = sum_p2_q[i];
      out_p2_d[i]  = out_p2_q[i];
      for (int k = 0; k < HIST_N; k++) hist_p2_d[i][k] = hist_p2_q[i][k];
      acc_new[i] = acc_q[i] + ACC_W'(axis_p0[i]);
      sum_new[i] = sum_p2_q[i] + SUM_W'(corr_p1_q[i]) - SUM_W'(hist_p2_q[i][HIST_N-1]);
    end

    // recal squashes anything in flight; bias survives until the next window completes
    if (bus.recal) begin
      cnt_d = '0;
      for (int i = 0; i < 3; i++) acc_d[i] = '0;
    end else begin
      if (take && state_q == ST_CAL) begin
        cnt_d = cnt_q + CNT_W'(1);
        for (int i = 0; i < 3; i++) acc_d[i] = acc_new[i];
        if (cal_done) begin
          cnt_d = '0;
          for (int i = 0; i < 3; i++) begin
            acc_d[i]    = '0;
            bias_d[i]   = DATA_W'(acc_new[i] >>> CAL_SHIFT);
            sum_p2_d[i] = '0;
            for (int k = 0; k < HIST_N; k++) hist_p2_d[i][k] = '0;
          end
        end
      end

      // Stage 1: bias removal with saturation
      if (take && state_q == ST_RUN) begin
        vld_p1_d = 1'b1;
        for (int i = 0; i < 3; i++) corr_p1_d[i] = sat_sub(axis_p0[i], bias_q[i]);
      end

      // Stage 2: running boxcar sum; history index 0 is newest
      if (vld_p1_q) begin
        vld_p2_d = 1'b1;
        for (int i = 0; i < 3; i++) begin
          sum_p2_d[i] = sum_new[i];
          out_p2_d[i] = DATA_W'(sum_new[i] >>> AVG_SHIFT);
          for (int k = HIST_N - 1; k > 0; k--) hist_p2_d[i][k] = hist_p2_q[i][k-1];
          hist_p2_d[i][0] = corr_p1_q[i];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_CAL;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rv_q     <= 1'b0;
      cnt_q    <= '0;
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        acc_q[i]     <= '0;
        bias_q[i]    <= '0;
        corr_p1_q[i] <= '0;
        sum_p2_q[i]  <= '0;
        out_p2_q[i]  <= '0;
        for (int k = 0; k < HIST_N; k++) hist_p2_q[i][k] <= '0;
      end
    end else begin
      rv_q     <= rv_d;
      cnt_q    <= cnt_d;
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
      for (int i = 0; i < 3; i++) begin
        acc_q[i]     <= acc_d[i];
        bias_q[i]    <= bias_d[i];
        corr_p1_q[i] <= corr_p1_d[i];
        sum_p2_q[i]  <= sum_p2_d[i];
        out_p2_q[i]  <= out_p2_d[i];
        for (int k = 0; k < HIST_N; k++) hist_p2_q[i][k] <= hist_p2_d[i][k];
      end
    end
  end

  assign bus.x_out      = out_p2_q[0];
  assign bus.y_out      = out_p2_q[1];
  assign bus.z_out      = out_p2_q[2];
  assign bus.out_valid  = vld_p2_q;
  assign bus.calibrated = calibrated;
endmodule

// File: tb/tb_imu_axis_filter.sv
// Scoreboard bench for imu_axis_filter: three instances cover averaging,
// pass-through saturation and big-endian byte order.
module tb_imu_axis_filter;
  logic clk;
  logic reset;
  int   cyc;
  int   nvec;
  int   nfail;

  imu_axis_filter_if if_a ();
  imu_axis_filter_if if_b ();
  imu_axis_filter_if if_c ();

  imu_axis_filter #(.CAL_SHIFT(2), .AVG_SHIFT(1), .BYTE_SWAP(1'b1)) u_a (
    .clk(clk), .reset(reset), .bus(if_a));
  imu_axis_filter #(.CAL_SHIFT(2), .AVG_SHIFT(0), .BYTE_SWAP(1'b1)) u_b (
    .clk(clk), .reset(reset), .bus(if_b));
  imu_axis_filter #(.CAL_SHIFT(2), .AVG_SHIFT(1), .BYTE_SWAP(1'b0)) u_c (
    .clk(clk), .reset(reset), .bus(if_c));

  typedef struct {
    int due;
    int x;
    int y;
    int z;
  } exp_t;

  exp_t sb [3][$];
  exp_t mon_e;

  logic               ov  [3];
  logic               cal [3];
  logic signed [15:0] xo  [3];
  logic signed [15:0] yo  [3];
  logic signed [15:0] zo  [3];

  assign ov[0] = if_a.out_valid;  assign cal[0] = if_a.calibrated;
  assign ov[1] = if_b.out_valid;  assign cal[1] = if_b.calibrated;
  assign ov[2] = if_c.out_valid;  assign cal[2] = if_c.calibrated;
  assign xo[0] = if_a.x_out;  assign yo[0] = if_a.y_out;  assign zo[0] = if_a.z_out;
  assign xo[1] = if_b.x_out;  assign yo[1] = if_b.y_out;  assign zo[1] = if_b.z_out;
  assign xo[2] = if_c.x_out;  assign yo[2] = if_c.y_out;  assign zo[2] = if_c.z_out;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Little-endian-on-the-wire frame: first byte of each pair is the low byte.
  function automatic logic [47:0] pack_le(input logic [15:0] x, input logic [15:0] y,
                                          input logic [15:0] z);
    return {x[7:0], x[15:8], y[7:0], y[15:8], z[7:0], z[15:8]};
  endfunction

  task automatic set_in(input int d, input logic [47:0] data, input logic v, input logic rc);
    case (d)
      0: begin if_a.raw_data = data; if_a.raw_valid = v; if_a.recal = rc; end
      1: begin if_b.raw_data = data; if_b.raw_valid = v; if_b.recal = rc; end
      default: begin if_c.raw_data = data; if_c.raw_valid = v; if_c.recal = rc; end
    endcase
  endtask

  task automatic check(input string name, input int d, input int act, input int req);
    nvec++;
    if (act != req) begin
      nfail++;
      $display("FAIL %s dut%0d: got %0d, required %0d", name, d, act, req);
    end
  endtask

  // Called just after a negedge; chk_cal < 0 skips the post-acceptance calibrated check.
  task automatic frame(input int d, input logic [47:0] data, input int hold, input int chk_cal,
                       input bit has_out, input int ex, input int ey, input int ez);
    exp_t e;
    set_in(d, data, 1'b1, 1'b0);
    if (has_out) begin
      e.due = cyc + 2;
      e.x = ex; e.y = ey; e.z = ez;
      sb[d].push_back(e);
    end
    @(negedge clk);
    if (chk_cal >= 0) check("calibrated_after_accept", d, int'(cal[d]), chk_cal);
    repeat (hold - 1) @(negedge clk);
    set_in(d, data, 1'b0, 1'b0);
    @(negedge clk);
  endtask

  task automatic calibrate(input int d, input logic [47:0] data, input int hold);
    for (int i = 0; i < 3; i++) begin
      frame(d, data, hold, 0, 1'b0, 0, 0, 0);
      check("calibrated_mid_window", d, int'(cal[d]), 0);
    end
    check("calibrated_before_last", d, int'(cal[d]), 0);
    frame(d, data, hold, 1, 1'b0, 0, 0, 0);
  endtask

  // Scoreboard monitor: every strobe must match the oldest pending expectation and its cycle.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (ov[d]) begin
        nvec++;
        if (sb[d].size() == 0) begin
          nfail++;
          $display("FAIL unexpected_valid dut%0d cyc %0d: got out_valid=1, required 0", d, cyc);
        end else begin
          mon_e = sb[d].pop_front();
          if (cyc != mon_e.due || xo[d] != mon_e.x || yo[d] != mon_e.y || zo[d] != mon_e.z) begin
            nfail++;
            $display("FAIL output dut%0d: got x=%0d y=%0d z=%0d at cyc %0d, required x=%0d y=%0d z=%0d at cyc %0d",
                     d, xo[d], yo[d], zo[d], cyc, mon_e.x, mon_e.y, mon_e.z, mon_e.due);
          end
        end
      end else if (sb[d].size() != 0 && sb[d][0].due <= cyc) begin
        nvec++;
        nfail++;
        mon_e = sb[d].pop_front();
        $display("FAIL missing_valid dut%0d cyc %0d: got out_valid=0, required 1 (due cyc %0d)",
                 d, cyc, mon_e.due);
      end
    end
  end

  initial begin
    nvec  = 0;
    nfail = 0;
    reset = 1'b1;
    for (int d = 0; d < 3; d++) set_in(d, 48'h0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check("reset_x", d, xo[d], 0);
      check("reset_out_valid", d, int'(ov[d]), 0);
      check("reset_calibrated", d, int'(cal[d]), 0);
    end

    // Instance A: calibration with 5-clk level pulses, bias = (16, -4, 7)
    calibrate(0, pack_le(16'h0010, 16'hFFFC, 16'h0007), 5);

    // Back-to-back frames at the maximum edge rate
    frame(0, pack_le(16'h0014, 16'hFFF8, 16'h000F), 1, -1, 1'b1,  2, -2,  4);
    frame(0, pack_le(16'h0014, 16'hFFF8, 16'h000F), 1, -1, 1'b1,  4, -4,  8);
    frame(0, pack_le(16'h000C, 16'hFFFC, 16'h0007), 1, -1, 1'b1,  0, -2,  4);
    frame(0, pack_le(16'h000B, 16'h0000, 16'hFFFF), 1, -1, 1'b1, -5,  2, -4);
    repeat (4) @(negedge clk);
    check("hold_x_between_strobes", 0, xo[0], -5);

    // recal in the same clk as a raw_valid edge: frame discarded, 4 fresh frames needed
    set_in(0, pack_le(16'h0100, 16'h0100, 16'h0100), 1'b1, 1'b1);
    @(negedge clk);
    set_in(0, 48'h0, 1'b0, 1'b0);
    check("calibrated_after_recal", 0, int'(cal[0]), 0);
    @(negedge clk);
    calibrate(0, pack_le(16'h0020, 16'h0000, 16'h0000), 1);
    frame(0, pack_le(16'h0022, 16'h0005, 16'hFFFD), 1, -1, 1'b1, 1, 2, -2);
    repeat (3) @(negedge clk);

    // recal while a frame sits in stage 1: the frame is squashed
    set_in(0, pack_le(16'h0040, 16'h0040, 16'h0040), 1'b1, 1'b0);
    @(negedge clk);
    set_in(0, 48'h0, 1'b0, 1'b1);
    @(negedge clk);
    set_in(0, 48'h0, 1'b0, 1'b0);
    check("calibrated_after_squash", 0, int'(cal[0]), 0);
    repeat (4) @(negedge clk);
    check("hold_x_after_squash", 0, xo[0], 1);

    // Two frames into a window, then an asynchronous mid-cycle reset
    frame(0, pack_le(16'h1000, 16'h0800, 16'h0400), 1, -1, 1'b0, 0, 0, 0);
    frame(0, pack_le(16'h1000, 16'h0800, 16'h0400), 1, -1, 1'b0, 0, 0, 0);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("async_reset_x", 0, xo[0], 0);
    check("async_reset_y", 0, yo[0], 0);
    check("async_reset_z", 0, zo[0], 0);
    check("async_reset_out_valid", 0, int'(ov[0]), 0);
    check("async_reset_calibrated", 0, int'(cal[0]), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("calibrated_idle_after_reset", 0, int'(cal[0]), 0);
    calibrate(0, pack_le(16'h0020, 16'h0000, 16'h0000), 1);
    frame(0, pack_le(16'h0030, 16'h0002, 16'hFFFE), 1, -1, 1'b1, 8, 1, -1);

    // Instance B (pass-through): bias = (16, -16, 16), saturation at both rails
    calibrate(1, pack_le(16'h0010, 16'hFFF0, 16'h0010), 1);
    frame(1, pack_le(16'h8000, 16'h7FFF, 16'h7FFF), 1, -1, 1'b1, -32768, 32767, 32751);
    frame(1, pack_le(16'h8010, 16'h7FEF, 16'hFFFB), 1, -1, 1'b1, -32768, 32767, -21);
    frame(1, pack_le(16'h0000, 16'h0000, 16'h0010), 1, -1, 1'b1, -16, 16, 0);

    // Instance C (first byte high): bias = (32, -16, 256)
    calibrate(2, 48'h0020_FFF0_0100, 1);
    frame(2, 48'h0030_FFF4_0104, 1, -1, 1'b1, 8, 2, 2);

    repeat (6) @(negedge clk);
    for (int d = 0; d < 3; d++) check("scoreboard_drained", d, sb[d].size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
